// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, data-length
// codes and the mapping from a length code to a data bit count.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP1  = 3'd3,
        ST_STOP2  = 3'd4
    } rx_state_t;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    function automatic logic [3:0] dataBits(input logic [1:0] len);
        logic [3:0] n;
        n = 4'd8;
        case (len)
            LEN_5:   n = 4'd5;
            LEN_6:   n = 4'd6;
            LEN_7:   n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver, one clk cycle per serial bit. The frame format is captured
// on the start bit and a completed frame is held until the consumer acks it.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       parity_en,
    input  logic       even_odd_parity,
    input  logic [1:0] data_bit_len,
    input  logic       num_of_stop_bits,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    rx_state_t  r_state;
    rx_state_t  w_next;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_parEn;
    logic       r_odd;
    logic [1:0] r_len;
    logic       r_twoStop;
    logic       r_parErr;
    logic       r_frmErr;
    logic [7:0] r_dataOut;
    logic       r_rxValid;
    logic       r_parityErr;
    logic       r_frameErr;
    logic       r_overrunErr;
    logic       w_lastData;
    logic       w_complete;
    logic       w_ack;

    assign w_lastData = ({1'b0, r_cnt} == (dataBits(r_len) - 4'd1));
    assign w_ack      = r_rxValid & rx_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion is flagged on the edge that samples the final stop bit.
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!sin) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_lastData) begin
                    w_next = r_parEn ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                w_next = ST_STOP1;
            end
            ST_STOP1: begin
                if (r_twoStop) begin
                    w_next = ST_STOP2;
                end else begin
                    w_next     = ST_IDLE;
                    w_complete = 1'b1;
                end
            end
            ST_STOP2: begin
                w_next     = ST_IDLE;
                w_complete = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Shift register is cleared at the start bit so unused upper bits read 0
    // and the parity XOR can cover all eight bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_shift   <= 8'h00;
            r_parEn   <= 1'b0;
            r_odd     <= 1'b0;
            r_len     <= LEN_8;
            r_twoStop <= 1'b0;
            r_parErr  <= 1'b0;
            r_frmErr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!sin) begin
                        r_cnt     <= 3'd0;
                        r_shift   <= 8'h00;
                        r_parEn   <= parity_en;
                        r_odd     <= even_odd_parity;
                        r_len     <= data_bit_len;
                        r_twoStop <= num_of_stop_bits;
                        r_parErr  <= 1'b0;
                        r_frmErr  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    r_shift[r_cnt] <= sin;
                    r_cnt          <= r_cnt + 3'd1;
                end
                ST_PARITY: begin
                    if (sin != ((^r_shift) ^ r_odd)) begin
                        r_parErr <= 1'b1;
                    end
                end
                ST_STOP1, ST_STOP2: begin
                    if (!sin) begin
                        r_frmErr <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A completion takes priority over an ack; overrun means the held frame
    // was replaced without being acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataOut    <= 8'h00;
            r_rxValid    <= 1'b0;
            r_parityErr  <= 1'b0;
            r_frameErr   <= 1'b0;
            r_overrunErr <= 1'b0;
        end else if (w_complete) begin
            r_dataOut    <= r_shift;
            r_rxValid    <= 1'b1;
            r_parityErr  <= r_parErr;
            r_frameErr   <= r_frmErr | ~sin;
            r_overrunErr <= r_rxValid & ~rx_ack;
        end else if (w_ack) begin
            r_rxValid    <= 1'b0;
            r_parityErr  <= 1'b0;
            r_frameErr   <= 1'b0;
            r_overrunErr <= 1'b0;
        end
    end

    assign data_out    = r_dataOut;
    assign rx_valid    = r_rxValid;
    assign parity_err  = r_parityErr;
    assign frame_err   = r_frameErr;
    assign overrun_err = r_overrunErr;

endmodule
